adder_axil_driver: RTL and testbench

AXI4-Lite initiator that runs one complete adder computation on the adder_amba peripheral without software. On a single command it writes operands r0/r1, writes ctrl (start + op), polls status bit 31, then reads result r2. Sits between a local command source (sequencer, button logic, soft core) and adder_amba_top's slave port.

---
 rtl/adder_axil_pkg.sv | 40 ++++
 rtl/adder_axil_driver_xfer.sv | 81 ++++++++
 rtl/adder_axil_driver.sv | 177 +++++++++++++++++
 tb/tb_adder_axil_driver.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_axil_pkg.sv
// Shared register map, response codes and state/error encodings for the
// adder_amba AXI4-Lite command driver.
package adder_axil_pkg;

  localparam logic [31:0] ADDR_R0   = 32'h0000_0000;
  localparam logic [31:0] ADDR_R1   = 32'h0000_0004;
  localparam logic [31:0] ADDR_R2   = 32'h0000_0008;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_000C;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_OP_BIT     = 1;
  localparam int STATUS_DONE_BIT = 31;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RESP    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_CTRL,
    ST_POLL,
    ST_GAP,
    ST_RD_RES,
    ST_FIN
  } state_e;

  // Control word that launches one operation: start bit plus op select.
  function automatic logic [31:0] ctrl_word(input logic op);
    ctrl_word = '0;
    ctrl_word[CTRL_START_BIT] = 1'b1;
    ctrl_word[CTRL_OP_BIT]    = op;
  endfunction

endpackage

// File: rtl/adder_axil_driver_xfer.sv
// Single-transaction AXI4-Lite engine: one read or one write per req, never
// overlapped. ack is a one-cycle strobe on the B or R handshake cycle.
module axil_single_xfer import adder_axil_pkg::*; #(
  parameter int         AW   = 32,
  parameter int         DW   = 32,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    resp,
  output logic [AW-1:0] m_awaddr,
  output logic [2:0]    m_awprot,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [DW-1:0] m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [1:0]    m_bresp,
  input  logic          m_bvalid,
  output logic          m_bready,
  output logic [AW-1:0] m_araddr,
  output logic [2:0]    m_arprot,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rvalid,
  output logic          m_rready
);

  // Handshake rule: every VALID is held with stable payload until its READY
  // is sampled high; BREADY/RREADY stay high from issue until the response
  // VALID is seen. The VALID/READY registers double as the pending flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_araddr  <= '0;
    end else if (req && !busy) begin
      if (we) begin
        m_awvalid <= 1'b1;
        m_wvalid  <= 1'b1;
        m_bready  <= 1'b1;
        m_awaddr  <= addr;
        m_wdata   <= wdata;
      end else begin
        m_arvalid <= 1'b1;
        m_rready  <= 1'b1;
        m_araddr  <= addr;
      end
    end else begin
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
      if (m_bready && m_bvalid)   m_bready  <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      if (m_rready && m_rvalid)   m_rready  <= 1'b0;
    end
  end

  assign busy     = m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready;
  assign ack      = (m_bready & m_bvalid) | (m_rready & m_rvalid);
  assign rdata    = m_rdata;
  assign resp     = m_bready ? m_bresp : m_rresp;
  assign m_wstrb  = '1;
  assign m_awprot = PROT;
  assign m_arprot = PROT;

endmodule

// File: rtl/adder_axil_driver.sv
// Runs one full adder_amba computation per i_start: write r0, r1, ctrl, poll
// status, read r2; reports result and error code with a one-cycle o_done.
module adder_axil_driver import adder_axil_pkg::*; #(
  parameter int                          C_M_AXI_ADDR_WIDTH = 32,
  parameter int                          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = '0,
  parameter logic [2:0]                  C_AXI_PROT         = 3'b000,
  parameter int                          C_POLL_MAX         = 16,
  parameter int                          C_POLL_GAP         = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            i_start,
  input  logic                            i_op,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_b,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_result,
  output logic [1:0]                      o_err,
  output logic [2:0]                      dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] A_R0   = C_BASE_ADDR + AW'(ADDR_R0);
  localparam logic [AW-1:0] A_R1   = C_BASE_ADDR + AW'(ADDR_R1);
  localparam logic [AW-1:0] A_R2   = C_BASE_ADDR + AW'(ADDR_R2);
  localparam logic [AW-1:0] A_CTRL = C_BASE_ADDR + AW'(ADDR_CTRL);

  state_e        state, state_n;
  err_e          fin_err;
  logic [DW-1:0] a_q, b_q;
  logic          op_q;
  logic [15:0]   poll_cnt, gap_cnt;

  logic          x_req, x_we, x_busy, x_ack;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic [1:0]    x_resp;
  logic          resp_ok;

  assign resp_ok = (x_resp == RESP_OKAY);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) state <= ST_IDLE;
    else                state <= state_n;
  end

  // Each bus state raises x_req only while the engine is idle, so exactly one
  // transaction is issued per state visit; x_ack moves the FSM on.
  always_comb begin
    state_n = state;
    x_req   = 1'b0;
    x_we    = 1'b0;
    x_addr  = A_CTRL;
    x_wdata = '0;
    fin_err = ERR_NONE;
    unique case (state)
      ST_IDLE: if (i_start) state_n = ST_WR_A;
      ST_WR_A: begin
        x_req = !x_busy; x_we = 1'b1; x_addr = A_R0; x_wdata = a_q;
        if (x_ack) state_n = ST_WR_B;
      end
      ST_WR_B: begin
        x_req = !x_busy; x_we = 1'b1; x_addr = A_R1; x_wdata = b_q;
        if (x_ack) state_n = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        x_req = !x_busy; x_we = 1'b1; x_addr = A_CTRL; x_wdata = DW'(ctrl_word(op_q));
        if (x_ack) state_n = ST_POLL;
      end
      ST_POLL: begin
        x_req = !x_busy; x_addr = A_CTRL;
        if (x_ack) begin
          if (x_rdata[STATUS_DONE_BIT]) state_n = ST_RD_RES;
          else if (poll_cnt + 16'd1 == 16'(C_POLL_MAX)) begin
            state_n = ST_FIN;
            fin_err = ERR_TIMEOUT;
          end else if (C_POLL_GAP == 0) state_n = ST_POLL;
          else state_n = ST_GAP;
        end
      end
      ST_GAP: if (gap_cnt == 16'(C_POLL_GAP - 1)) state_n = ST_POLL;
      ST_RD_RES: begin
        x_req = !x_busy; x_addr = A_R2;
        if (x_ack) state_n = ST_FIN;
      end
      ST_FIN: state_n = ST_IDLE;
    endcase
    // A non-OKAY response on any step overrides the normal successor.
    if (x_ack && !resp_ok) begin
      state_n = ST_FIN;
      fin_err = ERR_RESP;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      o_result <= '0;
      o_err    <= ERR_NONE;
    end else begin
      if (state == ST_IDLE && i_start) begin
        a_q  <= i_a;
        b_q  <= i_b;
        op_q <= i_op;
      end
      if (state == ST_IDLE) poll_cnt <= '0;
      else if (state == ST_POLL && x_ack && resp_ok && !x_rdata[STATUS_DONE_BIT])
        poll_cnt <= poll_cnt + 16'd1;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == ST_RD_RES && x_ack && resp_ok) o_result <= x_rdata;
      if (state_n == ST_FIN && state != ST_FIN) o_err <= fin_err;
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_FIN);
  assign dbg_state = state;

  axil_single_xfer #(.AW(AW), .DW(DW), .PROT(C_AXI_PROT)) u_xfer (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .req       (x_req),
    .we        (x_we),
    .addr      (x_addr),
    .wdata     (x_wdata),
    .busy      (x_busy),
    .ack       (x_ack),
    .rdata     (x_rdata),
    .resp      (x_resp),
    .m_awaddr  (M_AXI_AWADDR),
    .m_awprot  (M_AXI_AWPROT),
    .m_awvalid (M_AXI_AWVALID),
    .m_awready (M_AXI_AWREADY),
    .m_wdata   (M_AXI_WDATA),
    .m_wstrb   (M_AXI_WSTRB),
    .m_wvalid  (M_AXI_WVALID),
    .m_wready  (M_AXI_WREADY),
    .m_bresp   (M_AXI_BRESP),
    .m_bvalid  (M_AXI_BVALID),
    .m_bready  (M_AXI_BREADY),
    .m_araddr  (M_AXI_ARADDR),
    .m_arprot  (M_AXI_ARPROT),
    .m_arvalid (M_AXI_ARVALID),
    .m_arready (M_AXI_ARREADY),
    .m_rdata   (M_AXI_RDATA),
    .m_rresp   (M_AXI_RRESP),
    .m_rvalid  (M_AXI_RVALID),
    .m_rready  (M_AXI_RREADY)
  );

endmodule

// File: tb/tb_adder_axil_driver.sv
// Bench for adder_axil_driver: behavioural adder_amba slave, bus-sequence and
// result scoreboards, directed scenarios followed by randomized commands.
module tb_adder_axil_driver;

  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 2;
  localparam logic [31:0] NO_ERR_ADDR = 32'hFFFF_FFF0;

  // ---------------- clock / reset ----------------
  logic S_AXI_ACLK = 1'b0;
  logic S_AXI_ARESETN;
  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  logic        i_start, i_op;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done;
  logic [31:0] o_result;
  logic [1:0]  o_err;
  logic [2:0]  dbg_state;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  adder_axil_driver #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(32'h0),
    .C_AXI_PROT(3'b000), .C_POLL_MAX(POLL_MAX), .C_POLL_GAP(POLL_GAP)
  ) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_err(o_err),
    .dbg_state(dbg_state),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [33:0] exp_q[$];      // {err, result} per command
  logic [64:0] exp_bus_q[$];  // {we, addr, wdata} per bus transaction
  logic [31:0] last_result;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bus_chk(input logic [64:0] got);
    logic [64:0] e;
    if (exp_bus_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_unexpected: actual %0h required none", got);
    end else begin
      e = exp_bus_q.pop_front();
      check("bus_txn", got, e);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int          aw_delay, w_delay, done_delay;
  logic        never_done;
  logic [31:0] err_addr;
  logic [31:0] s_r0, s_r1, s_r2;
  int          polls_left;
  int          aw_cnt, w_cnt;
  logic        aw_have, w_have, b_pend, aw_prev_v, w_prev_v;
  logic [31:0] aw_addr_l, w_data_l, aw_prev_addr, w_prev_data;
  logic        aw_done, w_done, bad, rd_is_c, poll_seen;
  logic [31:0] wa, wd, rd;
  int          cyc = 0;
  int          last_r_c, idle;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_have && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_have && (w_cnt >= w_delay);
  assign M_AXI_ARREADY = M_AXI_ARVALID && !M_AXI_RVALID;

  always @(posedge S_AXI_ACLK) begin
    cyc++;
    if (!S_AXI_ARESETN) begin
      aw_have <= 1'b0; w_have <= 1'b0; aw_cnt <= 0; w_cnt <= 0; b_pend <= 1'b0;
      aw_prev_v <= 1'b0; w_prev_v <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
      rd_is_c = 1'b0;
    end else begin
      // payload must hold while VALID waits for READY
      if (aw_prev_v) check("awaddr_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_prev_addr});
      if (w_prev_v)  check("wdata_hold", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, w_prev_data});
      if (aw_have) check("awvalid_after_hs", M_AXI_AWVALID, 1'b0);
      if (w_have)  check("wvalid_after_hs", M_AXI_WVALID, 1'b0);
      if (M_AXI_AWVALID && !aw_prev_v && !aw_have)
        check("aw_w_rise_together", M_AXI_WVALID && !w_have, 1'b1);
      if (M_AXI_WVALID && !w_prev_v && !w_have)
        check("w_aw_rise_together", M_AXI_AWVALID && !aw_have, 1'b1);
      aw_prev_v <= M_AXI_AWVALID && !M_AXI_AWREADY;
      w_prev_v  <= M_AXI_WVALID && !M_AXI_WREADY;
      aw_prev_addr <= M_AXI_AWADDR;
      w_prev_data  <= M_AXI_WDATA;

      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_have <= 1'b1; aw_addr_l <= M_AXI_AWADDR; aw_cnt <= 0;
      end else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_have <= 1'b1; w_data_l <= M_AXI_WDATA; w_cnt <= 0;
      end else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;

      aw_done = aw_have || (M_AXI_AWVALID && M_AXI_AWREADY);
      w_done  = w_have || (M_AXI_WVALID && M_AXI_WREADY);
      wa = aw_have ? aw_addr_l : M_AXI_AWADDR;
      wd = w_have ? w_data_l : M_AXI_WDATA;
      if (aw_done && w_done && !b_pend) begin
        bus_chk({1'b1, wa, wd});
        bad = (wa == err_addr);
        M_AXI_BRESP  <= bad ? 2'b10 : 2'b00;
        M_AXI_BVALID <= 1'b1;
        b_pend       <= 1'b1;
        if (!bad) begin
          if (wa == 32'h0) s_r0 = wd;
          if (wa == 32'h4) s_r1 = wd;
          if (wa == 32'hC && wd[0]) begin
            s_r2 = wd[1] ? s_r0 + s_r1 : s_r0 - s_r1;
            polls_left = done_delay;
          end
        end
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0;
      end

      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        bus_chk({1'b0, M_AXI_ARADDR, 32'h0});
        rd_is_c = (M_AXI_ARADDR == 32'hC);
        if (rd_is_c && poll_seen) begin
          idle = cyc - last_r_c - 1;
          checks++;
          if (idle < POLL_GAP || idle > POLL_GAP + 2) begin
            errors++;
            $display("FAIL poll_gap: actual %0d idle cycles required %0d..%0d", idle, POLL_GAP, POLL_GAP + 2);
          end
        end
        bad = (M_AXI_ARADDR == err_addr);
        case (M_AXI_ARADDR)
          32'h0: rd = s_r0;
          32'h4: rd = s_r1;
          32'h8: rd = s_r2;
          32'hC: begin
            rd = {(!never_done && polls_left == 0), 31'b0};
            if (polls_left > 0) polls_left--;
          end
          default: rd = 32'hDEAD_BEEF;
        endcase
        M_AXI_RVALID <= 1'b1;
        M_AXI_RRESP  <= bad ? 2'b10 : 2'b00;
        M_AXI_RDATA  <= rd;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
        if (rd_is_c) begin
          last_r_c  = cyc;
          poll_seen = 1'b1;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  logic [33:0] mon_e;
  always @(negedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN && o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: actual o_done=1 required no pulse");
      end else begin
        mon_e = exp_q.pop_front();
        check("o_err", o_err, mon_e[33:32]);
        check("o_result", o_result, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic op, input bit wait_end);
    logic [64:0] seq[$];
    logic [31:0] res;
    logic [1:0]  err;
    int          nreads, start_cnt, n;
    bit          hit;
    seq = {};
    seq.push_back({1'b1, 32'h0, a});
    seq.push_back({1'b1, 32'h4, b});
    seq.push_back({1'b1, 32'hC, {30'b0, op, 1'b1}});
    nreads = never_done ? POLL_MAX : done_delay + 1;
    for (int i = 0; i < nreads; i++) seq.push_back({1'b0, 32'hC, 32'h0});
    if (!never_done) seq.push_back({1'b0, 32'h8, 32'h0});
    hit = 1'b0;
    foreach (seq[i]) begin
      if (!hit) begin
        exp_bus_q.push_back(seq[i]);
        if (seq[i][63:32] == err_addr) hit = 1'b1;
      end
    end
    err = hit ? 2'b01 : (never_done ? 2'b10 : 2'b00);
    res = (err == 2'b00) ? (op ? a + b : a - b) : last_result;
    last_result = res;
    exp_q.push_back({err, res});
    poll_seen = 1'b0;
    start_cnt = done_cnt;

    @(negedge S_AXI_ACLK);
    i_a = a; i_b = b; i_op = op; i_start = 1'b1;
    @(negedge S_AXI_ACLK);
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1'b1);
    // a start pulse with different operands while busy must be ignored
    i_a = $urandom; i_b = $urandom; i_op = ~op; i_start = 1'b1;
    @(negedge S_AXI_ACLK);
    i_start = 1'b0;
    if (wait_end) begin
      n = 0;
      while (done_cnt == start_cnt && n < 3000) begin
        @(negedge S_AXI_ACLK);
        n++;
      end
      if (done_cnt == start_cnt) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: actual no o_done after %0d cycles required one", n);
      end
      repeat (2) @(negedge S_AXI_ACLK);
      check("bus_seq_complete", exp_bus_q.size(), 0);
      check("busy_after_done", o_busy, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  int sel, n;
  initial begin
    S_AXI_ARESETN = 1'b0;
    i_start = 1'b0; i_op = 1'b0; i_a = '0; i_b = '0;
    aw_delay = 0; w_delay = 0; done_delay = 0; never_done = 1'b0;
    err_addr = NO_ERR_ADDR; last_result = '0; poll_seen = 1'b0;
    s_r0 = '0; s_r1 = '0; s_r2 = '0; polls_left = 0; last_r_c = 0;
    repeat (3) @(negedge S_AXI_ACLK);
    check("rst_busy_done", {o_busy, o_done}, 2'b00);
    check("rst_result", o_result, 32'h0);
    check("rst_err", o_err, 2'b00);
    check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    check("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR}, 96'h0);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);

    // basic subtract, then wrap cases
    done_delay = 1;
    run_cmd(32'd2, 32'd1, 1'b0, 1'b1);
    done_delay = 0;
    run_cmd(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    run_cmd(32'd5, 32'd7, 1'b0, 1'b1);

    // late AWREADY, immediate WREADY
    aw_delay = 3; w_delay = 0; done_delay = 2;
    run_cmd(32'd10, 32'd3, 1'b1, 1'b1);
    aw_delay = 0; w_delay = 2;
    run_cmd(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1);
    w_delay = 0;

    // slave error on the r1 write
    err_addr = 32'h4;
    run_cmd(32'd100, 32'd50, 1'b1, 1'b1);
    err_addr = NO_ERR_ADDR;

    // status never completes
    never_done = 1'b1;
    run_cmd(32'd8, 32'd8, 1'b1, 1'b1);
    never_done = 1'b0;

    // reset while a status read is in flight
    never_done = 1'b1;
    run_cmd(32'h11, 32'h22, 1'b1, 1'b0);
    n = 0;
    while (!(M_AXI_ARVALID && M_AXI_ARADDR == 32'hC) && n < 500) begin
      @(negedge S_AXI_ACLK);
      n++;
    end
    check("reach_poll_arvalid", M_AXI_ARVALID, 1'b1);
    S_AXI_ARESETN = 1'b0;
    @(negedge S_AXI_ACLK);
    check("midrst_arvalid", M_AXI_ARVALID, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_result", o_result, 32'h0);
    exp_q.delete();
    exp_bus_q.delete();
    last_result = '0;
    never_done = 1'b0;
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
    done_delay = 0;
    run_cmd(32'd9, 32'd4, 1'b0, 1'b1);

    // randomized commands with random slave timing and fault injection
    for (int k = 0; k < 16; k++) begin
      aw_delay   = $urandom_range(0, 3);
      w_delay    = $urandom_range(0, 3);
      done_delay = $urandom_range(0, POLL_MAX - 1);
      sel = $urandom_range(0, 7);
      never_done = (sel == 1);
      case ($urandom_range(0, 3))
        0: err_addr = 32'h0;
        1: err_addr = 32'h4;
        2: err_addr = 32'h8;
        default: err_addr = 32'hC;
      endcase
      if (sel != 0) err_addr = NO_ERR_ADDR;
      run_cmd($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    never_done = 1'b0;
    err_addr = NO_ERR_ADDR;

    repeat (5) @(negedge S_AXI_ACLK);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
